// File: rtl/grad_pkg.sv
// Shared Q24.8 constants and the batch-accumulator FSM state type.
package grad_pkg;

   localparam int FRACT_BITS = 8;

   localparam logic signed [31:0] Q24_8_MAX = 32'sh7FFFFFFF;
   localparam logic signed [31:0] Q24_8_MIN = 32'sh80000000;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      SCALE = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/sat_to_q24_8.sv
// Clamps a wide signed value to signed 32-bit Q24.8; purely combinational, no backpressure.
module sat_to_q24_8 #(
   parameter int ACC_W = 68
) (
   input  logic signed [ACC_W-1:0] din,
   output logic        [31:0]      dout,
   output logic                    sat
);
   import grad_pkg::*;

   localparam logic signed [ACC_W-1:0] HI = {{(ACC_W-32){1'b0}}, Q24_8_MAX};
   localparam logic signed [ACC_W-1:0] LO = {{(ACC_W-32){1'b1}}, Q24_8_MIN};

   always_comb begin
      dout = din[31:0];
      sat  = 1'b0;
      if (din > HI) begin
         dout = Q24_8_MAX;
         sat  = 1'b1;
      end else if (din < LO) begin
         dout = Q24_8_MIN;
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/grad_batch_accum.sv
// Batch mean of 2**LOG2_BATCH Q56.8 products, saturated to Q24.8; result valid 2 cycles after the last beat.
// s_ready is low from the last beat until the mean is taken downstream; batches never overlap.
module grad_batch_accum #(
   parameter int LOG2_BATCH = 4,
   parameter int ACC_W      = 64 + LOG2_BATCH
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [63:0] s_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic        m_sat
);
   import grad_pkg::*;

   localparam logic [LOG2_BATCH-1:0] LAST = '1;

   state_t                  state, next_state;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] mean;
   logic [LOG2_BATCH-1:0]   cnt;
   logic                    beat;
   logic                    acc_en, load_out, release_out;
   logic [31:0]             sat_data;
   logic                    sat_flag;

   assign beat = s_valid & s_ready & ~clr;
   assign mean = acc >>> LOG2_BATCH;

   sat_to_q24_8 #(.ACC_W(ACC_W)) u_sat (
      .din  (mean),
      .dout (sat_data),
      .sat  (sat_flag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACCUM;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (clr) begin
         next_state = ACCUM;
      end else begin
         case (state)
            ACCUM:   if (beat && cnt == LAST) next_state = SCALE;
            SCALE:   next_state = HOLD;
            HOLD:    if (m_ready) next_state = ACCUM;
            default: next_state = ACCUM;
         endcase
      end
   end

   always_comb begin
      acc_en      = 1'b0;
      load_out    = 1'b0;
      release_out = 1'b0;
      case (state)
         ACCUM:   acc_en      = beat;
         SCALE:   load_out    = 1'b1;
         HOLD:    release_out = m_ready;
         default: ;
      endcase
   end

   // cnt saturates at LAST in ACCUM; it only returns to 0 on the output handshake or clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ready <= 1'b0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_sat   <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
      end else begin
         s_ready <= (next_state == ACCUM);
         if (clr) begin
            acc     <= '0;
            cnt     <= '0;
            m_valid <= 1'b0;
            m_sat   <= 1'b0;
         end else begin
            if (acc_en) begin
               acc <= acc + {{(ACC_W-64){s_data[63]}}, s_data};
               if (cnt != LAST) cnt <= cnt + 1'b1;
            end
            if (load_out) begin
               m_data  <= sat_data;
               m_sat   <= sat_flag;
               m_valid <= 1'b1;
            end
            if (release_out) begin
               m_valid <= 1'b0;
               acc     <= '0;
               cnt     <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_grad_batch_accum.sv
// Bench for grad_batch_accum: directed vector table, clr/reset sequences, random batches vs a floor-mean model.
module tb_grad_batch_accum;

   logic        clk = 1'b0;
   logic        rst_n, clr, s_valid, s_ready, m_valid, m_ready, m_sat;
   logic [63:0] s_data;
   logic [31:0] m_data;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   grad_batch_accum #(.LOG2_BATCH(4), .ACC_W(68)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_sat   (m_sat)
   );

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [31:0] ed;
      logic        es;
      int          hold;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [63:0] d, input int gap);
      s_valid = 1'b0;
      repeat (gap) tick;
      s_valid = 1'b1;
      s_data  = d;
      for (int i = 0; i < 64; i++) begin
         if (s_ready) break;
         tick;
      end
      if (!s_ready) chk("s_ready_timeout", 64'(s_ready), 64'd1);
      tick;
      s_valid = 1'b0;
   endtask

   task automatic wait_out;
      int lat;
      lat = 0;
      while (!m_valid && lat < 64) begin
         tick;
         lat++;
      end
      chk("m_valid_rise", 64'(m_valid), 64'd1);
      chk("latency", 64'(lat), 64'd1);
   endtask

   task automatic drain(input int delay, input logic [31:0] ed, input logic es);
      chk("m_data", 64'(m_data), 64'(ed));
      chk("m_sat", 64'(m_sat), 64'(es));
      chk("s_ready_hold", 64'(s_ready), 64'd0);
      for (int i = 0; i < delay; i++) begin
         tick;
         chk("hold_valid", 64'(m_valid), 64'd1);
         chk("hold_data", 64'(m_data), 64'(ed));
         chk("hold_sat", 64'(m_sat), 64'(es));
         chk("hold_s_ready", 64'(s_ready), 64'd0);
      end
      m_ready = 1'b1;
      tick;
      m_ready = 1'b0;
      chk("m_valid_drop", 64'(m_valid), 64'd0);
      chk("s_ready_after", 64'(s_ready), 64'd1);
   endtask

   // Batch mean = floor(sum / 16), then clamped to the signed 32-bit range.
   task automatic model(input logic [63:0] bv[16], output logic [31:0] d, output logic s);
      logic signed [67:0] sum, q;
      sum = '0;
      for (int i = 0; i < 16; i++) sum = sum + $signed({{4{bv[i][63]}}, bv[i]});
      q = sum / 68'sd16;
      if (sum < 0 && (sum % 68'sd16) != 0) q = q - 68'sd1;
      s = 1'b0;
      d = q[31:0];
      if (q > 68'sd2147483647) begin
         d = 32'h7FFFFFFF;
         s = 1'b1;
      end else if (q < -68'sd2147483648) begin
         d = 32'h80000000;
         s = 1'b1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        vt[6];
      logic [63:0] bv[16];
      logic [31:0] ed;
      logic        es;
      logic [63:0] v;

      vt[0] = '{64'h0000_0000_0000_0100, 64'h0000_0000_0000_0100, 32'h00000100, 1'b0, 0};
      vt[1] = '{64'hFFFF_FFFF_FFFF_FE80, 64'hFFFF_FFFF_FFFF_FE80, 32'hFFFFFE80, 1'b0, 0};
      vt[2] = '{64'h0000_7FFF_FFFF_FF00, 64'h0000_7FFF_FFFF_FF00, 32'h7FFFFFFF, 1'b1, 1};
      vt[3] = '{64'hFFFF_8000_0000_0000, 64'hFFFF_8000_0000_0000, 32'h80000000, 1'b1, 2};
      vt[4] = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFFFFFF, 1'b0, 0};
      vt[5] = '{64'h0000_0000_0000_0200, 64'h0000_0000_0000_0200, 32'h00000200, 1'b0, 5};

      rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_m_sat", 64'(m_sat), 64'd0);
      rst_n = 1'b1;
      chk("s_ready_pre_edge", 64'(s_ready), 64'd0);
      tick;
      chk("s_ready_first_edge", 64'(s_ready), 64'd1);

      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 15; i++) send_beat(vt[k].a, 0);
         send_beat(vt[k].b, 0);
         chk("no_early_valid", 64'(m_valid), 64'd0);
         wait_out;
         drain(vt[k].hold, vt[k].ed, vt[k].es);
      end

      // Partial batch dropped by clr, including a beat offered alongside it.
      for (int i = 0; i < 7; i++) send_beat(64'h100, 0);
      clr = 1'b1; s_valid = 1'b1; s_data = 64'h100;
      tick;
      clr = 1'b0; s_valid = 1'b0;
      chk("clr_m_valid", 64'(m_valid), 64'd0);
      chk("clr_s_ready", 64'(s_ready), 64'd1);
      for (int i = 0; i < 16; i++) send_beat(64'h200, 0);
      wait_out;
      drain(0, 32'h200, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("no_second_result", 64'(m_valid), 64'd0);
      end

      // clr while a saturated result is held: m_data is kept, flags drop.
      for (int i = 0; i < 16; i++) send_beat(64'h0000_7FFF_FFFF_FF00, 0);
      wait_out;
      chk("hold_sat_set", 64'(m_sat), 64'd1);
      clr = 1'b1;
      tick;
      clr = 1'b0;
      chk("clr_hold_valid", 64'(m_valid), 64'd0);
      chk("clr_hold_sat", 64'(m_sat), 64'd0);
      chk("clr_hold_data", 64'(m_data), 64'h7FFFFFFF);
      chk("clr_hold_ready", 64'(s_ready), 64'd1);
      for (int i = 0; i < 16; i++) send_beat(64'h100, 0);
      wait_out;
      drain(0, 32'h100, 1'b0);

      // Asynchronous reset mid-batch.
      for (int i = 0; i < 7; i++) send_beat(64'h100, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_s_ready", 64'(s_ready), 64'd0);
      chk("arst_m_valid", 64'(m_valid), 64'd0);
      chk("arst_m_data", 64'(m_data), 64'd0);
      chk("arst_m_sat", 64'(m_sat), 64'd0);
      tick;
      rst_n = 1'b1;
      chk("arst_no_valid", 64'(m_valid), 64'd0);
      tick;
      chk("arst_s_ready_back", 64'(s_ready), 64'd1);
      for (int i = 0; i < 16; i++) send_beat(64'h300, 0);
      wait_out;
      drain(0, 32'h300, 1'b0);

      // Random batches with idle gaps and downstream stalls.
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < 16; i++) begin
            v = {$urandom, $urandom};
            v = $signed(v) >>> $urandom_range(0, 40);
            bv[i] = v;
         end
         model(bv, ed, es);
         for (int i = 0; i < 16; i++)
            send_beat(bv[i], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
         wait_out;
         drain($urandom_range(0, 3), ed, es);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
